// File: rtl/inst_fetch_ctrl_pkg.sv
// Shared fetch-bus widths and types for the instruction-fetch controller slice.
package inst_fetch_ctrl_pkg;

  localparam int unsigned PcWidth          = 32;
  localparam int unsigned InstWidth        = 32;
  localparam int unsigned FetchOutCntWidth = 2;

  typedef logic [FetchOutCntWidth-1:0] fetch_cnt_t;
  typedef logic [FetchOutCntWidth:0]   fetch_cnt_ext_t;

  typedef enum logic {
    REQ_IDLE,
    REQ_HOLD
  } req_state_e;

endpackage

// File: rtl/inst_fetch_ctrl_if.sv
// Instruction-SRAM request/response handshake bundle.
interface inst_fetch_ctrl_if
  import inst_fetch_ctrl_pkg::*;
#(
  parameter int unsigned PC_W   = PcWidth,
  parameter int unsigned INST_W = InstWidth
);

  logic              inst_sram_req_o;
  logic [PC_W-1:0]   inst_sram_addr_o;
  logic              inst_sram_addr_ok_i;
  logic              inst_sram_data_ok_i;
  logic [INST_W-1:0] inst_sram_rdata_i;

  modport master (
    output inst_sram_req_o,
    output inst_sram_addr_o,
    input  inst_sram_addr_ok_i,
    input  inst_sram_data_ok_i,
    input  inst_sram_rdata_i
  );

  modport slave (
    input  inst_sram_req_o,
    input  inst_sram_addr_o,
    output inst_sram_addr_ok_i,
    output inst_sram_data_ok_i,
    output inst_sram_rdata_i
  );

endinterface

// File: rtl/inst_fetch_ctrl_if_rdata_buffer.sv
// One-entry holding register for an instruction returned while ID stalls IF.
module if_rdata_buffer
  import inst_fetch_ctrl_pkg::*;
#(
  parameter int unsigned INST_W = InstWidth
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              capture_i,
  input  logic              release_i,
  input  logic              flush_i,
  input  logic [INST_W-1:0] rdata_i,
  output logic              ok_o,
  output logic [INST_W-1:0] rdata_o
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ok_o    <= 1'b0;
      rdata_o <= '0;
    end else if (flush_i) begin
      ok_o <= 1'b0;
    end else if (capture_i) begin
      ok_o    <= 1'b1;
      rdata_o <= rdata_i;
    end else if (release_i) begin
      ok_o <= 1'b0;
    end
  end

endmodule

// File: rtl/inst_fetch_ctrl.sv
// Instruction-SRAM fetch sequencer: request hold, outstanding tracking,
// flush cancellation of stale responses and the IF-side return buffer.
module inst_fetch_ctrl
  import inst_fetch_ctrl_pkg::*;
#(
  parameter int unsigned MAX_OUT = 2,
  parameter int unsigned PC_W    = PcWidth,
  parameter int unsigned INST_W  = InstWidth
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        preif_valid_i,
  input  logic                        preif_excep_i,
  input  logic [PC_W-1:0]             preif_pc_i,
  output logic                        preif_go_o,
  inst_fetch_ctrl_if.master           sram,
  input  logic                        id_allowin_i,
  input  logic                        excep_flush_i,
  output logic                        if_data_ok_o,
  output logic [INST_W-1:0]           if_rdata_o,
  output logic                        buf_ok_o,
  output logic [INST_W-1:0]           buf_rdata_o,
  output logic [FetchOutCntWidth-1:0] outstanding_o
);

  localparam fetch_cnt_ext_t MaxOut = fetch_cnt_ext_t'(MAX_OUT);
  localparam fetch_cnt_t     CntOne = fetch_cnt_t'(1);

  req_state_e      state;
  logic [PC_W-1:0] held_pc;
  logic            hold_cancelled;
  fetch_cnt_t      out_cnt;
  fetch_cnt_t      cancel_cnt;

  logic            hold;
  logic            issue;
  logic            req;
  logic            addr_ok;
  logic            data_ok;
  logic            addr_hs;
  logic            capture;
  fetch_cnt_t      out_nxt;
  fetch_cnt_t      cancel_on_flush;

  always_comb begin
    hold    = (state == REQ_HOLD);
    addr_ok = sram.inst_sram_addr_ok_i;
    data_ok = sram.inst_sram_data_ok_i;
    issue   = preif_valid_i & ~preif_excep_i & (fetch_cnt_ext_t'(out_cnt) < MaxOut)
            & ~buf_ok_o & ~excep_flush_i;
    // A request once raised is never retracted: while held, the latched PC
    // overrides whatever pre-IF currently presents, flush included.
    req     = hold | issue;
    addr_hs = req & addr_ok;

    sram.inst_sram_req_o  = req;
    sram.inst_sram_addr_o = hold ? held_pc : (issue ? preif_pc_i : '0);

    preif_go_o = ~excep_flush_i
               & ((addr_hs & ~hold_cancelled)
                | (preif_valid_i & preif_excep_i & (out_cnt == '0)));

    if_data_ok_o = data_ok & (cancel_cnt == '0) & ~excep_flush_i;
    if_rdata_o   = sram.inst_sram_rdata_i;
    capture      = if_data_ok_o & ~id_allowin_i;

    out_nxt = out_cnt + fetch_cnt_t'(addr_hs) - fetch_cnt_t'(data_ok);
    // Every response still owed after this edge is stale, plus the held
    // request that SRAM has not yet taken.
    cancel_on_flush = out_nxt + fetch_cnt_t'(hold & ~addr_ok);

    outstanding_o = out_cnt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= REQ_IDLE;
      held_pc        <= '0;
      hold_cancelled <= 1'b0;
      out_cnt        <= '0;
      cancel_cnt     <= '0;
    end else begin
      out_cnt <= out_nxt;

      if (excep_flush_i)
        cancel_cnt <= cancel_on_flush;
      else if (data_ok && cancel_cnt != '0)
        cancel_cnt <= cancel_cnt - CntOne;

      case (state)
        REQ_IDLE: begin
          if (req && !addr_ok) begin
            state          <= REQ_HOLD;
            held_pc        <= preif_pc_i;
            hold_cancelled <= 1'b0;
          end
        end
        REQ_HOLD: begin
          if (addr_ok) begin
            state          <= REQ_IDLE;
            hold_cancelled <= 1'b0;
          end else if (excep_flush_i) begin
            hold_cancelled <= 1'b1;
          end
        end
        default: state <= REQ_IDLE;
      endcase
    end
  end

  if_rdata_buffer #(
    .INST_W (INST_W)
  ) u_rdata_buffer (
    .clk       (clk),
    .rst_n     (rst_n),
    .capture_i (capture),
    .release_i (id_allowin_i),
    .flush_i   (excep_flush_i),
    .rdata_i   (sram.inst_sram_rdata_i),
    .ok_o      (buf_ok_o),
    .rdata_o   (buf_rdata_o)
  );

  a_out_cnt_underflow: assert property (@(posedge clk) disable iff (!rst_n)
    data_ok |-> (out_cnt != '0));
  a_out_cnt_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    (addr_hs && !data_ok) |-> (fetch_cnt_ext_t'(out_cnt) < MaxOut));
  a_buf_overrun: assert property (@(posedge clk) disable iff (!rst_n)
    !(buf_ok_o && if_data_ok_o));

endmodule
